// File: rtl/led_mode_ctrl.sv
// Key-driven LED mode controller: cycles OFF -> ON -> SLOW blink -> FAST blink -> OFF
// on each key_flag rising edge. All outputs are registered; the LED is active low.
module led_mode_ctrl #(
  parameter logic [24:0] SLOW_HALF = 25'd24_999_999,
  parameter logic [24:0] FAST_HALF = 25'd4_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_flag,
  output logic       led_out,
  output logic [1:0] mode,
  output logic       phase_tick
);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    ON   = 2'd1,
    SLOW = 2'd2,
    FAST = 2'd3
  } mode_t;

  mode_t       state, state_nxt;
  logic        key_d;
  logic        key_rise;
  logic        blink;
  logic        wrap;
  logic [24:0] half;
  logic [24:0] cnt, cnt_nxt;
  logic        phase, phase_nxt;

  assign key_rise = key_flag & ~key_d;
  assign blink    = (state == SLOW) || (state == FAST);
  assign half     = (state == SLOW) ? SLOW_HALF : FAST_HALF;
  // A key edge outranks a half-period wrap, so a mode change never emits a tick.
  assign wrap     = blink && (cnt == half) && !key_rise;
  assign mode     = state;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= OFF;
      key_d <= 1'b0;
    end else begin
      state <= state_nxt;
      key_d <= key_flag;
    end
  end

  always_comb begin
    state_nxt = state;
    if (key_rise) begin
      unique case (state)
        OFF:     state_nxt = ON;
        ON:      state_nxt = SLOW;
        SLOW:    state_nxt = FAST;
        FAST:    state_nxt = OFF;
        default: state_nxt = OFF;
      endcase
    end
  end

  // Every mode change restarts the blink lit, for a full half-period.
  always_comb begin
    cnt_nxt   = cnt;
    phase_nxt = phase;
    if (key_rise || !blink) begin
      cnt_nxt   = '0;
      phase_nxt = 1'b1;
    end else if (wrap) begin
      cnt_nxt   = '0;
      phase_nxt = ~phase;
    end else begin
      cnt_nxt   = cnt + 25'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt        <= '0;
      phase      <= 1'b1;
      led_out    <= 1'b1;
      phase_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      phase      <= phase_nxt;
      phase_tick <= wrap;
      unique case (state)
        OFF:     led_out <= 1'b1;
        ON:      led_out <= 1'b0;
        default: led_out <= ~phase;
      endcase
    end
  end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl: directed scenarios plus random key traffic, checked every
// cycle against a model that derives blink phase from cycles elapsed since mode entry.
module tb_led_mode_ctrl;

  localparam int SH = 9;
  localparam int FH = 3;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key_flag;
  logic       led_out;
  logic [1:0] mode;
  logic       phase_tick;

  int errors = 0;
  int checks = 0;

  // model state: values expected right after the most recent clock edge
  int   m_mode;
  int   m_n;
  logic m_key;
  logic m_led;
  logic m_tick;

  led_mode_ctrl #(.SLOW_HALF(25'(SH)), .FAST_HALF(25'(FH))) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_flag  (key_flag),
    .led_out   (led_out),
    .mode      (mode),
    .phase_tick(phase_tick)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int half_of(input int md);
    return (md == 2) ? SH : FH;
  endfunction

  // lit during even-numbered half-periods since the mode was entered
  function automatic logic lit_at(input int md, input int n);
    return ((n / (half_of(md) + 1)) % 2) == 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_key = 1'b0; m_led = 1'b1; m_tick = 1'b0;
  endtask

  task automatic model_edge(input logic k);
    logic rise;
    logic new_led;
    rise    = k && !m_key;
    m_key   = k;
    new_led = (m_mode == 0) ? 1'b1 : (m_mode == 1) ? 1'b0 : !lit_at(m_mode, m_n);
    if (rise) begin
      m_mode = (m_mode + 1) % 4;
      m_n    = 0;
      m_tick = 1'b0;
    end else if (m_mode >= 2) begin
      m_n    = m_n + 1;
      m_tick = (m_n % (half_of(m_mode) + 1)) == 0;
    end else begin
      m_n    = 0;
      m_tick = 1'b0;
    end
    m_led = new_led;
  endtask

  task automatic step(input string tag, input logic k);
    key_flag = k;
    @(posedge sys_clk);
    #1;
    model_edge(k);
    check({tag, ".mode"}, 32'(mode), 32'(m_mode));
    check({tag, ".led"}, 32'(led_out), 32'(m_led));
    check({tag, ".tick"}, 32'(phase_tick), 32'(m_tick));
  endtask

  task automatic goto_mode(input int target);
    for (int i = 0; i < 8 && m_mode != target; i++) begin
      step("goto", 1'b1);
      step("goto", 1'b0);
    end
    check("goto_reached", 32'(mode), 32'(target));
  endtask

  initial begin
    sys_rst_n = 1'b1;
    key_flag  = 1'b0;
    model_reset();
    #2 sys_rst_n = 1'b0;
    #1;
    check("rst.mode", 32'(mode), 32'd0);
    check("rst.led", 32'(led_out), 32'd1);
    check("rst.tick", 32'(phase_tick), 32'd0);
    @(posedge sys_clk);
    #1;
    check("rst_hold.mode", 32'(mode), 32'd0);
    check("rst_hold.led", 32'(led_out), 32'd1);
    sys_rst_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 100; i++) step("idle", 1'b0);

    // four single-cycle presses, 50 cycles apart
    for (int p = 0; p < 4; p++) begin
      step("press", 1'b1);
      check("press.mode_k", 32'(mode), 32'((p + 1) % 4));
      for (int i = 0; i < 49; i++) step("press_gap", 1'b0);
    end

    // slow blink observation
    goto_mode(2);
    for (int i = 0; i < 60; i++) step("slow", 1'b0);

    // fast blink, then key held 20 cycles -> exactly one advance
    goto_mode(3);
    for (int i = 0; i < 20; i++) step("fast", 1'b0);
    for (int i = 0; i < 20; i++) step("hold", 1'b1);
    check("hold.mode", 32'(mode), 32'd0);
    step("hold_rel", 1'b0);

    // key edge coincident with slow counter at its last value
    goto_mode(2);
    for (int i = 0; i < 30 && (m_n % (SH + 1)) != SH; i++) step("coin_wait", 1'b0);
    check("coin.aligned", 32'(m_n % (SH + 1)), 32'(SH));
    step("coin", 1'b1);
    check("coin.mode", 32'(mode), 32'd3);
    step("coin_after", 1'b0);
    check("coin.led_lit", 32'(led_out), 32'd0);

    // async reset mid-dark in fast mode
    goto_mode(3);
    for (int i = 0; i < 30 && (m_n % (2 * (FH + 1))) != FH + 2; i++) step("dark_wait", 1'b0);
    check("dark.led", 32'(led_out), 32'd1);
    check("dark.mode", 32'(mode), 32'd3);
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst.mode", 32'(mode), 32'd0);
    check("arst.led", 32'(led_out), 32'd1);
    check("arst.tick", 32'(phase_tick), 32'd0);
    model_reset();
    #3 sys_rst_n = 1'b1;
    step("post_rst", 1'b1);
    check("post_rst.mode", 32'(mode), 32'd1);
    step("post_rst", 1'b0);

    // random key traffic, including held keys
    for (int i = 0; i < 1500; i++) begin
      logic k;
      k = key_flag ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
      step("rand", k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
